// File: rtl/seg7_scan_decoder_if.sv
// seg7_scan_decoder_if: scanned display inputs and decoded digit outputs.
interface seg7_scan_decoder_if;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [15:0] value;
    logic [3:0]  digit_valid;
    logic        frame_valid;
    logic        err;
    logic [1:0]  err_digit;
    modport master (output seg, an, input value, digit_valid, frame_valid, err, err_digit);
    modport slave  (input seg, an, output value, digit_valid, frame_valid, err, err_digit);
endinterface

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: recovers hex digits from a multiplexed 7-segment display scan.
module seg7_scan_decoder #(
    parameter int STABLE_CYCLES  = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit AN_ACTIVE_LOW  = 1'b0
) (
    input logic clk,
    input logic rst_n,
    seg7_scan_decoder_if.slave bus
);
    typedef enum logic {TRACK, HOLD} state_t;
    state_t      state_q, state_d;
    logic [6:0]  seg_q, seg_d;
    logic [3:0]  an_q, an_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] value_q, value_d;
    logic [3:0]  dv_q, dv_d, seen_q, seen_d, hit, code;
    logic        fv_q, fv_d, err_q, err_d, legal, chg, acc;
    logic [1:0]  errd_q, errd_d, idx;

    assign seg_d = SEG_ACTIVE_LOW ? ~bus.seg : bus.seg;
    assign an_d  = AN_ACTIVE_LOW ? ~bus.an : bus.an;
    assign chg   = {an_d, seg_d} != {an_q, seg_q};
    assign cnt_d = chg ? 8'd1 : cnt_q + {7'd0, cnt_q != 8'hFF};
    assign acc   = state_q == TRACK && cnt_q == 8'(STABLE_CYCLES) && $onehot(an_q);
    assign idx   = {an_q[3] | an_q[2], an_q[3] | an_q[1]};
    assign hit   = 4'b0001 << idx;

    always_comb begin
        legal = 1'b1;
        code  = 4'h0;
        case (seg_q)
            7'h3F: code = 4'h0;
            7'h06: code = 4'h1;
            7'h5B: code = 4'h2;
            7'h4F: code = 4'h3;
            7'h66: code = 4'h4;
            7'h6D: code = 4'h5;
            7'h7D: code = 4'h6;
            7'h07: code = 4'h7;
            7'h7F: code = 4'h8;
            7'h6F: code = 4'h9;
            7'h77: code = 4'hA;
            7'h7C: code = 4'hB;
            7'h39: code = 4'hC;
            7'h5E: code = 4'hD;
            7'h79: code = 4'hE;
            7'h71: code = 4'hF;
            default: legal = 1'b0;
        endcase
    end

    // A change always wins over accept so a moving input never parks in HOLD
    always_comb begin
        state_d = chg ? TRACK : acc ? HOLD : state_q;
        value_d = value_q;
        dv_d    = dv_q;
        seen_d  = seen_q;
        errd_d  = errd_q;
        fv_d    = 1'b0;
        err_d   = 1'b0;
        if (acc && legal) begin
            value_d[{idx, 2'b00} +: 4] = code;
            dv_d   = dv_q | hit;
            fv_d   = (seen_q | hit) == 4'hF;
            seen_d = fv_d ? 4'h0 : seen_q | hit;
        end else if (acc) begin
            err_d  = 1'b1;
            errd_d = idx;
            dv_d   = dv_q & ~hit;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= TRACK;
            seg_q   <= 7'h00;
            an_q    <= 4'h0;
            cnt_q   <= 8'h00;
            value_q <= 16'h0000;
            dv_q    <= 4'h0;
            seen_q  <= 4'h0;
            fv_q    <= 1'b0;
            err_q   <= 1'b0;
            errd_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            cnt_q   <= cnt_d;
            value_q <= value_d;
            dv_q    <= dv_d;
            seen_q  <= seen_d;
            fv_q    <= fv_d;
            err_q   <= err_d;
            errd_q  <= errd_d;
        end
    end

    assign bus.value       = value_q;
    assign bus.digit_valid = dv_q;
    assign bus.frame_valid = fv_q;
    assign bus.err         = err_q;
    assign bus.err_digit   = errd_q;
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb_seg7_scan_decoder: directed vector table plus timing and reset sequences.
module tb_seg7_scan_decoder;
    typedef struct {
        logic [3:0]  an;
        logic [6:0]  seg;
        int          cyc;
        logic [15:0] val;
        logic [3:0]  dv;
        int          errs;
        int          fvs;
        logic [1:0]  errd;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rstb_n = 1'b0;
    int checks = 0;
    int failures = 0;
    int a_err = 0, a_fv = 0, b_err = 0, b_fv = 0;
    vec_t v[15];

    always #5 clk = ~clk;

    seg7_scan_decoder_if ia();
    seg7_scan_decoder_if ib();
    seg7_scan_decoder dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
    seg7_scan_decoder #(.STABLE_CYCLES(4), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1))
        dut_b (.clk(clk), .rst_n(rstb_n), .bus(ib));

    // Pulse outputs are tallied just after each rising edge
    always @(posedge clk) begin
        #1;
        a_err += int'(ia.err);
        a_fv  += int'(ia.frame_valid);
        b_err += int'(ib.err);
        b_fv  += int'(ib.frame_valid);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_b(input string tag);
        chk({tag, "_value"}, 32'(ib.value), 32'h0);
        chk({tag, "_dv"}, 32'(ib.digit_valid), 32'h0);
        chk({tag, "_fv"}, 32'(ib.frame_valid), 32'h0);
        chk({tag, "_err"}, 32'(ib.err), 32'h0);
        chk({tag, "_errd"}, 32'(ib.err_digit), 32'h0);
    endtask

    initial begin
        int e0, f0;
        v[0]  = '{4'b0001, 7'h06, 5,  16'h0001, 4'b0001, 0, 0, 2'd0};
        v[1]  = '{4'b0010, 7'h5B, 5,  16'h0021, 4'b0011, 0, 0, 2'd0};
        v[2]  = '{4'b0100, 7'h4F, 5,  16'h0321, 4'b0111, 0, 0, 2'd0};
        v[3]  = '{4'b1000, 7'h66, 5,  16'h4321, 4'b1111, 0, 1, 2'd0};
        v[4]  = '{4'b0100, 7'h7E, 6,  16'h4321, 4'b1011, 1, 0, 2'd2};
        v[5]  = '{4'b0011, 7'h3F, 10, 16'h4321, 4'b1011, 0, 0, 2'd2};
        v[6]  = '{4'b0000, 7'h3F, 10, 16'h4321, 4'b1011, 0, 0, 2'd2};
        v[7]  = '{4'b0001, 7'h3F, 6,  16'h4320, 4'b1011, 0, 0, 2'd2};
        v[8]  = '{4'b0010, 7'h3F, 3,  16'h4320, 4'b1011, 0, 0, 2'd2};
        v[9]  = '{4'b0010, 7'h06, 3,  16'h4320, 4'b1011, 0, 0, 2'd2};
        v[10] = '{4'b0010, 7'h3F, 3,  16'h4320, 4'b1011, 0, 0, 2'd2};
        v[11] = '{4'b0010, 7'h06, 3,  16'h4320, 4'b1011, 0, 0, 2'd2};
        v[12] = '{4'b0010, 7'h6D, 5,  16'h4350, 4'b1011, 0, 0, 2'd2};
        v[13] = '{4'b0100, 7'h7D, 5,  16'h4650, 4'b1111, 0, 0, 2'd2};
        v[14] = '{4'b1000, 7'h71, 5,  16'hF650, 4'b1111, 0, 1, 2'd2};
        ia.an = 4'h0;
        ia.seg = 7'h00;
        ib.an = 4'hF;
        ib.seg = 7'h7F;
        repeat (3) @(negedge clk);
        chk("a_rst_value", 32'(ia.value), 32'h0);
        chk("a_rst_dv", 32'(ia.digit_valid), 32'h0);
        chk("a_rst_fv", 32'(ia.frame_valid), 32'h0);
        chk("a_rst_err", 32'(ia.err), 32'h0);
        chk("a_rst_errd", 32'(ia.err_digit), 32'h0);
        chk_reset_b("b_rst");
        rst_n = 1'b1;
        e0 = a_err;
        ia.an = 4'b0001;
        ia.seg = 7'h7F;
        repeat (4) @(negedge clk);
        chk("a_lat_early_dv", 32'(ia.digit_valid), 32'h0);
        @(negedge clk);
        chk("a_lat_dv", 32'(ia.digit_valid), 32'h1);
        chk("a_lat_value", 32'(ia.value), 32'h0008);
        @(negedge clk);
        chk("a_lat_err", 32'(a_err - e0), 32'h0);
        for (int i = 0; i < 15; i++) begin
            e0 = a_err;
            f0 = a_fv;
            ia.an = v[i].an;
            ia.seg = v[i].seg;
            repeat (v[i].cyc) @(negedge clk);
            chk($sformatf("v%0d_value", i), 32'(ia.value), 32'(v[i].val));
            chk($sformatf("v%0d_dv", i), 32'(ia.digit_valid), 32'(v[i].dv));
            chk($sformatf("v%0d_errs", i), 32'(a_err - e0), 32'(v[i].errs));
            chk($sformatf("v%0d_fvs", i), 32'(a_fv - f0), 32'(v[i].fvs));
            chk($sformatf("v%0d_errd", i), 32'(ia.err_digit), 32'(v[i].errd));
        end
        rstb_n = 1'b1;
        ib.an = 4'b1110;
        ib.seg = 7'b1000000;
        repeat (6) @(negedge clk);
        chk("b_acc_dv", 32'(ib.digit_valid), 32'h1);
        chk("b_acc_value", 32'(ib.value), 32'h0);
        repeat (2) @(negedge clk);
        rstb_n = 1'b0;
        @(negedge clk);
        chk_reset_b("b_mid");
        rstb_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("b_rerun_early_dv", 32'(ib.digit_valid), 32'h0);
        @(negedge clk);
        chk("b_rerun_dv", 32'(ib.digit_valid), 32'h1);
        e0 = b_err;
        ib.an = 4'b1101;
        ib.seg = 7'h79;
        repeat (5) @(negedge clk);
        chk("b_d1_value", 32'(ib.value), 32'h0010);
        chk("b_d1_dv", 32'(ib.digit_valid), 32'h3);
        chk("b_d1_err", 32'(b_err - e0), 32'h0);
        chk("b_fv_none", 32'(b_fv), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/seg7_scan_decoder.md
SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, SHALL set the consecutive identical samples needed to accept a digit (legal 2..255).
REQ-002 Parameter SEG_ACTIVE_LOW, default 0, SHALL invert seg before decode when 1.
REQ-003 Parameter AN_ACTIVE_LOW, default 0, SHALL invert an before decode when 1.
REQ-004 clk  input  1  sole clock; all logic SHALL update on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 seg  input  7  segment bus, bit0=a .. bit6=g (after polarity fix, 1=lit).
REQ-007 an  input  4  digit select, bit i = digit i (after polarity fix, 1=selected).
REQ-008 value  output  16  decoded hex, nibble i = digit i.
REQ-009 digit_valid  output  4  bit i SHALL be 1 when nibble i holds a legally decoded pattern.
REQ-010 frame_valid  output  1  one-cycle pulse: all four digits accepted since last pulse.
REQ-011 err  output  1  one-cycle pulse: accepted pattern not in decode table.
REQ-012 err_digit  output  2  index of digit that caused the latest err; held until next err.

Function
REQ-013 seg and an SHALL pass through one input register (seg_q, an_q) after polarity correction; all decode uses registered values.
REQ-014 Decode table SHALL be (hex g..a): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 B=7C C=39 D=5E E=79 F=71; any other pattern is illegal.
REQ-015 Counter cnt (8 bits) SHALL load 1 when {an_q,seg_q} differs from previous sample, else increment, saturating at 255.
REQ-016 FSM states TRACK and HOLD; reset state TRACK.
REQ-017 TRACK -> HOLD SHALL occur when cnt == STABLE_CYCLES and an_q is one-hot (accept event).
REQ-018 HOLD -> TRACK SHALL occur on any change of {an_q,seg_q}; no second accept while in HOLD.
REQ-019 an_q zero or multi-hot SHALL never accept, never error, and leave FSM in TRACK.
REQ-020 Accept, legal pattern, digit i: value[4i+3:4i] <= code, digit_valid[i] <= 1, seen[i] <= 1.
REQ-021 Accept, illegal pattern, digit i: err pulse, err_digit <= i, digit_valid[i] <= 0, nibble i unchanged, seen[i] unchanged.
REQ-022 Outputs SHALL update on the edge following the accept condition: input stable from before edge k -> outputs change at edge k+STABLE_CYCLES.
REQ-023 When a legal accept makes seen == 4'b1111, frame_valid SHALL pulse on that same output edge and seen SHALL clear to 0.
REQ-024 Re-accepting an already-seen digit SHALL update its nibble but SHALL NOT pulse frame_valid unless seen completes.
REQ-025 Input change on the exact cycle cnt would reach STABLE_CYCLES SHALL suppress the accept (cnt reloads 1).

Reset
REQ-026 rst_n low at a clock edge SHALL set value=0, digit_valid=0, frame_valid=0, err=0, err_digit=0, seen=0, cnt=0, seg_q=0, an_q=0, FSM=TRACK.
REQ-027 Reset mid-count or in HOLD SHALL discard progress; first accept after release needs a full STABLE_CYCLES run.
REQ-028 No output SHALL change asynchronously to clk.

Verification
REQ-029 Defaults; an=0001, seg=7F held 6 cycles -> value[3:0]=8, digit_valid=0001 exactly 4 edges after first registered sample; no err.
REQ-030 Scan digits 0..3 with seg 06,5B,4F,66, each held 5 cycles -> value=16'h4321, digit_valid=1111, single frame_valid pulse on digit 3 accept.
REQ-031 an=0100, seg=7E held 6 cycles -> err pulse once, err_digit=2, digit_valid[2]=0, value[11:8] unchanged.
REQ-032 an=0010 with seg toggling 3F/06 every 3 cycles (STABLE_CYCLES=4) -> no accept, no err, outputs unchanged.
REQ-033 an=0011 or 0000, seg=3F held 10 cycles -> no accept, no err; then an=0001 held -> accepts value[3:0]=0.
REQ-034 SEG_ACTIVE_LOW=1, AN_ACTIVE_LOW=1, an=1110, seg=7'b1000000 held -> value[3:0]=0, digit_valid[0]=1; rst_n low 1 cycle mid-hold -> all outputs 0, re-accept after full run.
